// File: rtl/alu_writeback_if.sv
// alu_writeback_if -- ALU result bus into the writeback queue.
//
// Handshake: the producer (master) holds in_valid and the payload stable
// for a cycle; a transfer happens at the rising edge where in_valid and
// in_ready are both 1. in_valid while in_ready is 0 transfers nothing and
// the producer may change or drop the payload freely. in_ready never
// depends on in_valid in the same cycle.
//
// Signals:
//   in_valid     master->slave  ALU result presented
//   in_ready     slave->master  queue can accept an entry this cycle
//   in_optcode   master->slave  4-bit ALU optcode of the result
//   in_result    master->slave  DATA_W ALU result
//   in_flags     master->slave  4-bit flags {n,z,v,c}
//   in_rd        master->slave  4-bit destination register index
//   in_set_flags master->slave  request flag update
interface alu_writeback_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_optcode;
  logic [DATA_W-1:0] in_result;
  logic [3:0]        in_flags;
  logic [3:0]        in_rd;
  logic              in_set_flags;

  modport master (
    output in_valid, in_optcode, in_result, in_flags, in_rd, in_set_flags,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_optcode, in_result, in_flags, in_rd, in_set_flags,
    output in_ready
  );
endinterface

// File: rtl/alu_writeback.sv
// alu_writeback -- queued writeback stage for an ALU.
//
// ALU results enter a small FIFO and are committed in order, one per cycle,
// into a 16-entry register file and a flag register. Operand reads come
// straight from the register file (no forwarding); instead a hazard output
// warns when a queued entry is going to overwrite a register being read.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_if (slave)        ALU result bus, valid/ready handshake
//   wb_stall             holds the queue head (no commit) this cycle
//   rs1_addr, rs2_addr   operand read addresses
//   rs1_data, rs2_data   operand data (register 0 reads as 0)
//   hazard               queued register write targets rs1_addr or rs2_addr
//   flags_n_z_v_c        architectural flag register
//   illegal_op           sticky: an undefined optcode was committed
//   retired_count        16-bit wrapping count of committed entries
module alu_writeback #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  alu_writeback_if.slave    in_if,
  input  logic              wb_stall,
  input  logic [3:0]        rs1_addr,
  input  logic [3:0]        rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              hazard,
  output logic [3:0]        flags_n_z_v_c,
  output logic              illegal_op,
  output logic [15:0]       retired_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Optcode classes: 0..8 write the register file, 9 is CMP, 10..15 illegal.
  localparam logic [3:0] OP_LAST_WR = 4'd8;
  localparam logic [3:0] OP_CMP     = 4'd9;

  // Queue payload, one slot per entry
  logic [3:0]        op_q  [DEPTH];
  logic [DATA_W-1:0] res_q [DEPTH];
  logic [3:0]        flg_q [DEPTH];
  logic [3:0]        rd_q  [DEPTH];
  logic              sf_q  [DEPTH];
  logic [DEPTH-1:0]  vld_q;

  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [DATA_W-1:0] regs_q [16];
  logic [3:0]        flags_q;
  logic              illegal_q;
  logic [15:0]       retired_q;

  logic push, commit;
  logic [3:0] head_op;
  logic       head_wr, head_cmp, head_ill;

  // in_ready depends only on registered occupancy and rst
  assign in_if.in_ready = (count_q < DEPTH_C) && !rst;
  assign push   = in_if.in_valid && in_if.in_ready;
  // count_q only counts entries pushed at earlier edges, so an entry can
  // never commit at its own push edge.
  assign commit = (count_q != '0) && !wb_stall && !rst;

  assign head_op  = op_q[head_q];
  assign head_wr  = (head_op <= OP_LAST_WR);
  assign head_cmp = (head_op == OP_CMP);
  assign head_ill = !head_wr && !head_cmp;

  always_comb begin
    count_d = count_q;
    case ({push, commit})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Payload storage needs no reset: vld_q and count_q qualify every use.
  always_ff @(posedge clk) begin
    if (push) begin
      op_q[tail_q]  <= in_if.in_optcode;
      res_q[tail_q] <= in_if.in_result;
      flg_q[tail_q] <= in_if.in_flags;
      rd_q[tail_q]  <= in_if.in_rd;
      sf_q[tail_q]  <= in_if.in_set_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      vld_q     <= '0;
      flags_q   <= 4'b0000;
      illegal_q <= 1'b0;
      retired_q <= 16'h0000;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      count_q <= count_d;
      // push and commit never address the same slot: a push needs a free
      // slot and a commit needs an occupied one.
      if (push) begin
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + 1'b1;
      end
      if (commit) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + 1'b1;
        retired_q     <= retired_q + 16'h0001;
        if (head_wr) begin
          if (rd_q[head_q] != 4'd0) regs_q[rd_q[head_q]] <= res_q[head_q];
          if (sf_q[head_q]) flags_q <= flg_q[head_q];
        end else if (head_cmp) begin
          flags_q <= flg_q[head_q];
        end
        if (head_ill) illegal_q <= 1'b1;
      end
    end
  end

  // Reads see the state after the last edge; register 0 is forced to zero
  assign rs1_data = (rs1_addr == 4'd0) ? '0 : regs_q[rs1_addr];
  assign rs2_data = (rs2_addr == 4'd0) ? '0 : regs_q[rs2_addr];

  // Only queued entries that will really write a nonzero register count;
  // rd != 0 also rules out a match on a zero read address.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (op_q[i] <= OP_LAST_WR) && (rd_q[i] != 4'd0) &&
          ((rd_q[i] == rs1_addr) || (rd_q[i] == rs2_addr)))
        hazard = 1'b1;
    end
  end

  assign flags_n_z_v_c = flags_q;
  assign illegal_op    = illegal_q;
  assign retired_count = retired_q;

endmodule
